// File: rtl/puf_response_collector.sv
// puf_response_collector: fires the arbiter PUF, majority-votes each response bit, packs bytes and feeds uart_tx.
module puf_response_collector #(
  parameter int NUM_BITS = 128,
  parameter int VOTES    = 5,
  parameter int SETTLE   = 16,
  localparam int OW      = $clog2(NUM_BITS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          puf_out,
  output logic          puf_in,
  output logic          chal_advance,
  output logic [7:0]    uart_data,
  output logic          uart_send,
  input  logic          uart_busy,
  output logic          busy,
  output logic          done,
  output logic [OW-1:0] ones_count
);
  typedef enum logic [2:0] {IDLE, LOW, HIGH, DECIDE, SEND, WAITTX, FIN} state_t;
  localparam int CW = $clog2(SETTLE);
  localparam int VW = $clog2(VOTES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(SETTLE - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VOTES - 1);
  localparam logic [VW-1:0] V_HALF = VW'(VOTES / 2);
  localparam logic [OW-1:0] B_ALL  = OW'(NUM_BITS);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] votes_q, votes_d, tally_q, tally_d;
  logic [OW-1:0] bits_q, bits_d, ones_q, ones_d;
  logic [7:0]    shift_q, shift_d, data_q, data_d;
  logic [1:0]    sync_q;
  logic          puf_in_q, puf_in_d, chal_q, chal_d, send_q, send_d;
  logic          busy_q, busy_d, done_q, done_d, dec;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      votes_q  <= '0;
      tally_q  <= '0;
      bits_q   <= '0;
      ones_q   <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      sync_q   <= '0;
      puf_in_q <= 1'b0;
      chal_q   <= 1'b0;
      send_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      votes_q  <= votes_d;
      tally_q  <= tally_d;
      bits_q   <= bits_d;
      ones_q   <= ones_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      sync_q   <= {sync_q[0], puf_out};
      puf_in_q <= puf_in_d;
      chal_q   <= chal_d;
      send_q   <= send_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    votes_d = votes_q;
    tally_d = tally_q;
    bits_d  = bits_q;
    ones_d  = ones_q;
    shift_d = shift_q;
    data_d  = data_q;
    dec     = tally_q > V_HALF;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOW;
        cnt_d   = '0;
        votes_d = '0;
        tally_d = '0;
        bits_d  = '0;
        ones_d  = '0;
        shift_d = '0;
      end
      LOW: begin
        cnt_d   = cnt_q == C_LAST ? '0 : cnt_q + CW'(1);
        state_d = cnt_q == C_LAST ? HIGH : LOW;
      end
      HIGH: begin
        cnt_d = cnt_q == C_LAST ? '0 : cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          tally_d = tally_q + VW'(sync_q[1]);
          votes_d = votes_q + VW'(1);
          state_d = votes_q == V_LAST ? DECIDE : LOW;
        end
      end
      DECIDE: begin
        shift_d = {shift_q[6:0], dec};
        ones_d  = ones_q + OW'(dec);
        tally_d = '0;
        votes_d = '0;
        bits_d  = bits_q + OW'(1);
        state_d = bits_q[2:0] == 3'd7 ? SEND : LOW;
      end
      SEND: if (!uart_busy) begin
        data_d  = shift_q;
        state_d = WAITTX;
      end
      // First WAITTX cycle is skipped so uart_busy has time to rise.
      WAITTX: if (cnt_q == '0) cnt_d = CW'(1);
      else if (!uart_busy) begin
        cnt_d   = '0;
        state_d = bits_q == B_ALL ? FIN : LOW;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    puf_in_d = state_d == HIGH;
    chal_d   = state_d == DECIDE;
    done_d   = state_d == FIN;
    busy_d   = state_d != IDLE && state_d != FIN;
    send_d   = state_q == SEND && state_d == WAITTX;
  end
  assign puf_in       = puf_in_q;
  assign chal_advance = chal_q;
  assign uart_send    = send_q;
  assign uart_data    = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign ones_count   = ones_q;
endmodule

// File: tb/tb_puf_response_collector.sv
// tb_puf_response_collector: randomized vote patterns checked against a majority-vote byte packing model.
`timescale 1ns/1ps
module tb_puf_response_collector;
  localparam int NB = 16, NV = 3, NS = 4, OW = $clog2(NB + 1), NE = NB * NV;
  logic clk = 0, reset = 1, start = 0;
  logic puf_out, puf_in, chal_advance, uart_send, uart_busy, busy, done;
  logic [7:0] uart_data;
  logic [OW-1:0] ones_count;
  int n_chk = 0, n_pass = 0;
  int ucnt = 0, cyc = 0;
  bit hold = 0, async_mode = 0, tog = 0, vote_bit = 0, clr = 0, prev_pin = 0;
  bit vq[NE];
  int ev_idx = 0, chal_n = 0, done_n = 0, first_send_cyc = -1, chal_first = 0;
  logic [7:0] rx[$];
  logic [7:0] eb[2];
  int eones;
  puf_response_collector #(.NUM_BITS(NB), .VOTES(NV), .SETTLE(NS)) dut (
    .clk(clk), .reset(reset), .start(start), .puf_out(puf_out), .puf_in(puf_in),
    .chal_advance(chal_advance), .uart_data(uart_data), .uart_send(uart_send),
    .uart_busy(uart_busy), .busy(busy), .done(done), .ones_count(ones_count));
  always #5 clk = ~clk;
  always #33 tog = ~tog;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ucnt <= uart_send ? 20 : (ucnt > 0 ? ucnt - 1 : 0);
  assign uart_busy = ucnt != 0 || hold;
  assign puf_out = async_mode ? tog : vote_bit;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  initial forever begin
    @(negedge clk);
    if (clr) begin
      ev_idx = 0; chal_n = 0; done_n = 0; first_send_cyc = -1; chal_first = 0;
      rx.delete();
    end else begin
      if (puf_in && !prev_pin) begin
        vote_bit = vq[ev_idx % NE];
        ev_idx++;
      end
      if (chal_advance) chal_n++;
      if (done) begin
        done_n++;
        chk("busy_at_done", busy, 0);
      end
      if (uart_send) begin
        chk("send_vs_busy", uart_busy, 0);
        if (first_send_cyc < 0) begin
          first_send_cyc = cyc;
          chal_first = chal_n;
        end
        rx.push_back(uart_data);
      end
    end
    prev_pin = puf_in;
  end
  task automatic gen(input int mode);
    int s;
    bit b;
    for (int i = 0; i < NE; i++)
      vq[i] = mode == 0 ? 1'b1 : mode == 1 ? ((i / NV) % 2 == 0 ? (i % NV != 2) : (i % NV == 2)) : 1'($urandom_range(0, 1));
    eones = 0;
    eb[0] = 0;
    eb[1] = 0;
    for (int k = 0; k < NB; k++) begin
      s = vq[NV*k] + vq[NV*k+1] + vq[NV*k+2];
      b = 2 * s > NV;
      eones += b;
      eb[k / 8][7 - k % 8] = b;
    end
  endtask
  task automatic begin_run(output int t0);
    clr = 1;
    tick();
    clr = 0;
    start = 1;
    t0 = cyc;
    tick();
    start = 0;
  endtask
  task automatic run(input int mode, input bit mid, input bit do_hold);
    int n, t0, viol;
    bit held;
    gen(mode);
    begin_run(t0);
    n = 0;
    held = 0;
    while (done_n == 0 && n < 3000) begin
      start = mid && n == 120;
      if (do_hold && !held && chal_n == 8) begin
        held = 1;
        hold = 1;
        viol = 0;
        repeat (100) begin
          tick();
          viol += int'(uart_send) + int'(puf_in);
        end
        hold = 0;
        chk("hold_quiet", viol, 0);
        tick();
        chk("send_after_hold", uart_send, 1);
        chk("data_after_hold", uart_data, eb[0]);
      end
      tick();
      n++;
    end
    start = 0;
    chk("run_done", done_n != 0, 1);
    repeat (5) tick();
    chk("done_once", done_n, 1);
    chk("byte_count", rx.size(), 2);
    for (int i = 0; i < 2 && i < rx.size(); i++) chk("byte", rx[i], eb[i]);
    chk("chal_count", chal_n, NB);
    chk("ones", ones_count, eones);
    chk("busy_idle", busy, 0);
  endtask
  initial begin
    int n, t0, pop;
    repeat (2) tick();
    chk("rst_puf_in", puf_in, 0);
    chk("rst_chal", chal_advance, 0);
    chk("rst_send", uart_send, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", uart_data, 0);
    chk("rst_ones", ones_count, 0);
    reset = 0;
    tick();
    run(0, 0, 0);
    run(1, 0, 0);
    run(0, 0, 1);
    run(2, 1, 0);
    repeat (3) run(2, 0, 0);
    gen(2);
    begin_run(t0);
    n = 0;
    while (chal_n < 10 && n < 2000) begin
      tick();
      n++;
    end
    chk("pre_reset_chal", chal_n, 10);
    repeat (10) tick();
    reset = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_puf_in", puf_in, 0);
    chk("mid_rst_send", uart_send, 0);
    chk("mid_rst_chal", chal_advance, 0);
    chk("mid_rst_data", uart_data, 0);
    chk("mid_rst_ones", ones_count, 0);
    repeat (3) tick();
    chk("rst_no_chal", chal_n, 10);
    chk("rst_no_send", rx.size(), 1);
    reset = 0;
    tick();
    run(2, 0, 0);
    async_mode = 1;
    begin_run(t0);
    n = 0;
    while (done_n == 0 && n < 3000) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("async_done", done_n, 1);
    chk("async_first_send_late", first_send_cyc - t0 >= 200, 1);
    chk("async_chal_before_send", chal_first, 8);
    chk("async_bytes", rx.size(), 2);
    chk("async_chal", chal_n, NB);
    pop = 0;
    foreach (rx[i]) pop += $countones(rx[i]);
    chk("async_ones", ones_count, pop);
    async_mode = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
